// File: rtl/viterbi_acs_traceback.sv
// Hard-decision Viterbi core for the K=3, rate-1/2 (111,101) code: 4-state ACS per
// symbol, survivor decisions stored per step, traceback from state 0 at frame end.
module viterbi_acs_traceback #(
   parameter int PM_W    = 6,
   parameter int STEP_W  = 6,
   parameter int INIT_PM = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [1:0] in_sym,
   input  logic       in_last,
   output logic       in_ready,
   output logic       out_valid,
   output logic       out_bit,
   output logic       out_last
);

   localparam logic [1:0] ST_ACCEPT = 2'd0;
   localparam logic [1:0] ST_TRACE  = 2'd1;
   localparam logic [1:0] ST_EMIT   = 2'd2;
   localparam int DEPTH = 2 ** STEP_W;
   localparam logic [PM_W-1:0] PM_START = PM_W'(INIT_PM);

   logic [1:0]        state_reg;
   logic [STEP_W:0]   step_reg;
   logic [STEP_W:0]   n_reg;
   logic [PM_W-1:0]   pm_reg [4];
   logic [PM_W:0]     pm_new [4];
   logic [PM_W-1:0]   pm_norm [4];
   logic [3:0]        dec_new;
   logic [3:0]        dec_mem [DEPTH];
   logic [3:0]        dec_word;
   logic [1:0]        tb_st_reg;
   logic [DEPTH-1:0]  bits_reg;
   logic              out_valid_reg;
   logic              out_bit_reg;
   logic              out_last_reg;
   logic              all_msb;
   logic              accept;
   logic              frame_end;

   assign in_ready  = (state_reg == ST_ACCEPT);
   assign accept    = in_valid && in_ready;
   assign frame_end = in_last || (step_reg[STEP_W-1:0] == {STEP_W{1'b1}});
   assign out_valid = out_valid_reg;
   assign out_bit   = out_bit_reg;
   assign out_last  = out_last_reg;

   // Next state gi = {b, s1}; predecessors {s1,0} and {s1,1}. The s0=1 predecessor
   // always expects the complement of the s0=0 pair, so its distance uses ~x0.
   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_acs
         localparam int B  = gi / 2;
         localparam int S1 = gi % 2;
         localparam logic [1:0] EXP0 = 2'(((B ^ S1) << 1) | B);
         logic [1:0]    x0;
         logic [1:0]    x1;
         logic [PM_W:0] cand0;
         logic [PM_W:0] cand1;
         assign x0    = in_sym ^ EXP0;
         assign x1    = ~x0;
         assign cand0 = {1'b0, pm_reg[2*S1]} + {{PM_W{1'b0}}, x0[1]} + {{PM_W{1'b0}}, x0[0]};
         assign cand1 = {1'b0, pm_reg[2*S1+1]} + {{PM_W{1'b0}}, x1[1]} + {{PM_W{1'b0}}, x1[0]};
         assign dec_new[gi] = (cand1 < cand0);
         assign pm_new[gi]  = dec_new[gi] ? cand1 : cand0;
         assign pm_norm[gi] = pm_new[gi][PM_W] ? {PM_W{1'b1}}
                            : {pm_new[gi][PM_W-1] & ~all_msb, pm_new[gi][PM_W-2:0]};
      end
   endgenerate

   assign all_msb = pm_new[0][PM_W-1] & pm_new[1][PM_W-1] & pm_new[2][PM_W-1] & pm_new[3][PM_W-1];

   // Small decision store read combinationally so each traceback step takes one cycle.
   assign dec_word = dec_mem[step_reg[STEP_W-1:0]];

   always_ff @(posedge clk) begin
      if (accept) begin
         dec_mem[step_reg[STEP_W-1:0]] <= dec_new;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg     <= ST_ACCEPT;
         step_reg      <= '0;
         n_reg         <= '0;
         tb_st_reg     <= 2'b00;
         out_valid_reg <= 1'b0;
         out_bit_reg   <= 1'b0;
         out_last_reg  <= 1'b0;
         pm_reg[0]     <= '0;
         for (int k = 1; k < 4; k++) pm_reg[k] <= PM_START;
      end else begin
         case (state_reg)
            ST_ACCEPT: begin
               if (accept) begin
                  if (frame_end) begin
                     n_reg     <= step_reg + 1'b1;
                     state_reg <= ST_TRACE;
                     tb_st_reg <= 2'b00;
                     pm_reg[0] <= '0;
                     for (int k = 1; k < 4; k++) pm_reg[k] <= PM_START;
                  end else begin
                     step_reg <= step_reg + 1'b1;
                     for (int k = 0; k < 4; k++) pm_reg[k] <= pm_norm[k];
                  end
               end
            end
            ST_TRACE: begin
               bits_reg[step_reg[STEP_W-1:0]] <= tb_st_reg[1];
               tb_st_reg <= {tb_st_reg[0], dec_word[tb_st_reg]};
               if (step_reg == '0) begin
                  // Bit 0 bypasses the buffer so the first output is registered on time.
                  state_reg     <= ST_EMIT;
                  out_valid_reg <= 1'b1;
                  out_bit_reg   <= tb_st_reg[1];
                  out_last_reg  <= (n_reg == 1);
                  step_reg      <= 1;
               end else begin
                  step_reg <= step_reg - 1'b1;
               end
            end
            ST_EMIT: begin
               if (step_reg == n_reg) begin
                  state_reg     <= ST_ACCEPT;
                  step_reg      <= '0;
                  out_valid_reg <= 1'b0;
                  out_bit_reg   <= 1'b0;
                  out_last_reg  <= 1'b0;
               end else begin
                  out_bit_reg  <= bits_reg[step_reg[STEP_W-1:0]];
                  out_last_reg <= (step_reg == n_reg - 1'b1);
                  step_reg     <= step_reg + 1'b1;
               end
            end
            default: state_reg <= ST_ACCEPT;
         endcase
      end
   end

endmodule

// File: tb/tb_viterbi_acs_traceback.sv
// Scoreboard bench for viterbi_acs_traceback: expected bits and their output cycles
// are queued as frames are sent and checked as out_valid bits appear.
module tb_viterbi_acs_traceback;
   localparam int PM_W = 6;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid;
   logic [1:0] in_sym;
   logic       in_last;
   logic       in_ready;
   logic       out_valid;
   logic       out_bit;
   logic       out_last;

   always #5 clk = ~clk;

   viterbi_acs_traceback #(.PM_W(PM_W), .STEP_W(6), .INIT_PM(16)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sym(in_sym), .in_last(in_last),
      .in_ready(in_ready), .out_valid(out_valid), .out_bit(out_bit), .out_last(out_last)
   );

   typedef struct {
      bit b;
      bit l;
      int c;
   } exp_t;

   exp_t       q[$];
   exp_t       mon_e;
   int         total = 0;
   int         bad = 0;
   int         cyc = 0;
   int         t_acc = 0;
   int         ov_seen = 0;
   logic [1:0] fr [64];
   bit         expb [64];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int got, input int want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, want, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (out_valid === 1'b1) begin
         ov_seen++;
         if (q.size() == 0) begin
            chk("spurious_out", 1, 0);
         end else begin
            mon_e = q.pop_front();
            chk("out_bit", int'(out_bit), int'(mon_e.b));
            chk("out_last", int'(out_last), int'(mon_e.l));
            chk("out_cycle", cyc, mon_e.c);
            $display("out bit=%0d last=%0d cycle=%0d", out_bit, out_last, cyc);
         end
      end
      if (reset === 1'b0 && in_valid && in_ready === 1'b1) begin
         chk("pm_range", int'(dut.pm_new[0][PM_W] | dut.pm_new[1][PM_W]
                              | dut.pm_new[2][PM_W] | dut.pm_new[3][PM_W]), 0);
      end
   end

   // Independent decode with unbounded integer metrics and the same tie rule.
   function automatic void ref_decode(input int n);
      int pm [4];
      int np [4];
      bit d [64][4];
      int st;
      pm = '{0, 16, 16, 16};
      for (int t = 0; t < n; t++) begin
         for (int ns = 0; ns < 4; ns++) begin
            int b, s1, c [2];
            b = ns >> 1;
            s1 = ns & 1;
            for (int s0 = 0; s0 < 2; s0++) begin
               int c0, c1;
               c0 = b ^ s1 ^ s0;
               c1 = b ^ s0;
               c[s0] = pm[s1*2 + s0] + ((int'(fr[t][1]) ^ c0) + (int'(fr[t][0]) ^ c1));
            end
            d[t][ns] = (c[1] < c[0]);
            np[ns] = (c[1] < c[0]) ? c[1] : c[0];
         end
         pm = np;
      end
      st = 0;
      for (int t = n - 1; t >= 0; t--) begin
         expb[t] = bit'(st >> 1);
         st = ((st & 1) << 1) | int'(d[t][st]);
      end
   endfunction

   task automatic send(input logic [1:0] s, input logic l);
      int w = 0;
      while (in_ready !== 1'b1 && w < 500) begin
         @(negedge clk);
         w++;
      end
      if (in_ready !== 1'b1) chk("ready_timeout", 0, 1);
      in_valid = 1'b1;
      in_sym   = s;
      in_last  = l;
      t_acc    = cyc;
      $display("in sym=%b last=%0d cycle=%0d", s, l, cyc);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic run_frame(input int n, input bit use_last, input bit push);
      exp_t e;
      for (int i = 0; i < n; i++) send(fr[i], use_last && (i == n - 1));
      if (push) begin
         for (int i = 0; i < n; i++) begin
            e.b = expb[i];
            e.l = (i == n - 1);
            e.c = t_acc + n + 1 + i;
            q.push_back(e);
         end
      end
   endtask

   task automatic wait_done();
      int w = 0;
      while ((q.size() != 0 || in_ready !== 1'b1) && w < 500) begin
         @(negedge clk);
         w++;
      end
      chk("drain_timeout", q.size(), 0);
   endtask

   task automatic load_t1();
      logic [1:0] t1 [6];
      bit         e1 [6];
      t1 = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
      e1 = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      for (int i = 0; i < 6; i++) begin
         fr[i]   = t1[i];
         expb[i] = e1[i];
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int ov_before;
      reset = 1'b1; in_valid = 1'b0; in_sym = 2'b00; in_last = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_out_bit", int'(out_bit), 0);
      chk("rst_out_last", int'(out_last), 0);

      // Clean frame, then the same frame with one symbol error
      load_t1();
      run_frame(6, 1'b1, 1'b1);
      wait_done();
      fr[2] = 2'b10;
      run_frame(6, 1'b1, 1'b1);
      wait_done();

      // Eight zero symbols, measure the busy window
      for (int i = 0; i < 8; i++) begin fr[i] = 2'b00; expb[i] = 1'b0; end
      run_frame(8, 1'b1, 1'b1);
      cnt = 0;
      while (in_ready !== 1'b1 && cnt < 300) begin cnt++; @(negedge clk); end
      chk("ready_low_cycles", cnt, 16);
      wait_done();

      // Forced end at step 63
      for (int i = 0; i < 64; i++) begin fr[i] = 2'b00; expb[i] = 1'b0; end
      run_frame(64, 1'b0, 1'b1);
      wait_done();
      chk("step_back_zero", int'(dut.step_reg), 0);

      // Reset during the third traceback cycle aborts the frame
      load_t1();
      run_frame(6, 1'b1, 1'b0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("ready_after_reset", int'(in_ready), 1);
      ov_before = ov_seen;
      repeat (20) @(negedge clk);
      chk("aborted_no_out", ov_seen - ov_before, 0);
      load_t1();
      run_frame(6, 1'b1, 1'b1);
      wait_done();

      // Single-symbol frame
      fr[0] = 2'b11;
      expb[0] = 1'b0;
      run_frame(1, 1'b1, 1'b1);
      wait_done();

      // Random 64-symbol frames against the reference decode
      for (int r = 0; r < 2; r++) begin
         for (int i = 0; i < 64; i++) fr[i] = 2'($urandom_range(0, 3));
         ref_decode(64);
         run_frame(64, 1'b1, 1'b1);
         wait_done();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
